// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between the EX/MEM and MEM/WB registers.
//   Non-memory entries pass straight to the output register.
//   Loads and stores are sized (B/H/W/D, signed/unsigned) and checked for
//   misalignment. Legal accesses go out on a valid/ready data-memory port,
//   with one transaction outstanding at a time.
// Ports:
//   clk, reset (async, active low)
//   in_*    : EX/MEM entry with valid/ready handshake
//   dmem_*  : request (valid/ready) and load response (valid only)
//   out_*   : MEM/WB entry with valid/ready handshake
module mem_stage #(
   parameter int XLEN = 64,
   parameter int REGW = 6,
   localparam int NB = XLEN / 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_aluresult,
   input  logic [REGW-1:0] in_rd,
   input  logic [XLEN-1:0] in_store_data,
   input  logic            in_mem_active,
   input  logic            in_load,
   input  logic [2:0]      in_funct3,
   output logic            dmem_req_valid,
   input  logic            dmem_req_ready,
   output logic [XLEN-1:0] dmem_req_addr,
   output logic            dmem_req_we,
   output logic [XLEN-1:0] dmem_req_wdata,
   output logic [NB-1:0]   dmem_req_be,
   input  logic            dmem_resp_valid,
   input  logic [XLEN-1:0] dmem_resp_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_aluresult,
   output logic [XLEN-1:0] out_loadeddata,
   output logic [REGW-1:0] out_rd,
   output logic            out_is_load,
   output logic            out_fault
);
   localparam int OFFW = $clog2(NB);

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;
   state_t state_reg, state_next;

   // Holds in_ready low until the first clock after reset is released.
   logic awake_reg;

   logic [XLEN-1:0] addr_reg, addr_next;
   logic [XLEN-1:0] wdata_reg, wdata_next;
   logic [NB-1:0]   be_reg, be_next;
   logic            we_reg, we_next;
   logic [OFFW-1:0] off_reg, off_next;
   logic [2:0]      funct3_reg, funct3_next;
   logic [REGW-1:0] rd_reg, rd_next;
   logic [XLEN-1:0] alu_reg, alu_next;

   logic            out_valid_reg, out_valid_next;
   logic [XLEN-1:0] out_alu_reg, out_alu_next;
   logic [XLEN-1:0] out_ld_reg, out_ld_next;
   logic [REGW-1:0] out_rd_reg, out_rd_next;
   logic            out_is_load_reg, out_is_load_next;
   logic            out_fault_reg, out_fault_next;

   // Decode of the entry at the input.
   logic [OFFW-1:0] in_off;
   logic [3:0]      in_size;
   logic            in_fault;
   logic [NB-1:0]   in_be;
   logic            accept;

   assign in_off = in_aluresult[OFFW-1:0];

   always_comb begin
      in_size = 4'd8;
      case (in_funct3[1:0])
         2'b00:   in_size = 4'd1;
         2'b01:   in_size = 4'd2;
         2'b10:   in_size = 4'd4;
         default: in_size = 4'd8;
      endcase
   end

   // Sizes are powers of two, so alignment is a mask test on the offset.
   assign in_fault = ((4'(in_off) & (in_size - 4'd1)) != 4'd0)
                   || (in_funct3 == 3'b111)
                   || ((XLEN == 32) && ((in_funct3 == 3'b011) || (in_funct3 == 3'b110)));

   // A lane is enabled when it falls inside [off, off+size).
   generate
      for (genvar gi = 0; gi < NB; gi++) begin : g_be
         assign in_be[gi] = (4'(gi) >= 4'(in_off)) && (4'(gi) < (4'(in_off) + in_size));
      end
   endgenerate

   assign in_ready = awake_reg && (state_reg == IDLE) && (!out_valid_reg || out_ready);
   assign accept   = in_valid && in_ready;

   // Load result: bring the addressed bytes down to lane 0, then extend.
   logic [XLEN-1:0] resp_shifted;
   logic [XLEN-1:0] load_ext;

   assign resp_shifted = dmem_resp_data >> {off_reg, 3'b000};

   always_comb begin
      load_ext = resp_shifted;
      case (funct3_reg[1:0])
         2'b00: load_ext = funct3_reg[2] ? XLEN'(resp_shifted[7:0])
                                         : XLEN'($signed(resp_shifted[7:0]));
         2'b01: load_ext = funct3_reg[2] ? XLEN'(resp_shifted[15:0])
                                         : XLEN'($signed(resp_shifted[15:0]));
         2'b10: load_ext = funct3_reg[2] ? XLEN'(resp_shifted[31:0])
                                         : XLEN'($signed(resp_shifted[31:0]));
         default: load_ext = resp_shifted;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg       <= IDLE;
         awake_reg       <= 1'b0;
         addr_reg        <= '0;
         wdata_reg       <= '0;
         be_reg          <= '0;
         we_reg          <= 1'b0;
         off_reg         <= '0;
         funct3_reg      <= '0;
         rd_reg          <= '0;
         alu_reg         <= '0;
         out_valid_reg   <= 1'b0;
         out_alu_reg     <= '0;
         out_ld_reg      <= '0;
         out_rd_reg      <= '0;
         out_is_load_reg <= 1'b0;
         out_fault_reg   <= 1'b0;
      end else begin
         state_reg       <= state_next;
         awake_reg       <= 1'b1;
         addr_reg        <= addr_next;
         wdata_reg       <= wdata_next;
         be_reg          <= be_next;
         we_reg          <= we_next;
         off_reg         <= off_next;
         funct3_reg      <= funct3_next;
         rd_reg          <= rd_next;
         alu_reg         <= alu_next;
         out_valid_reg   <= out_valid_next;
         out_alu_reg     <= out_alu_next;
         out_ld_reg      <= out_ld_next;
         out_rd_reg      <= out_rd_next;
         out_is_load_reg <= out_is_load_next;
         out_fault_reg   <= out_fault_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      addr_next        = addr_reg;
      wdata_next       = wdata_reg;
      be_next          = be_reg;
      we_next          = we_reg;
      off_next         = off_reg;
      funct3_next      = funct3_reg;
      rd_next          = rd_reg;
      alu_next         = alu_reg;
      out_valid_next   = out_valid_reg;
      out_alu_next     = out_alu_reg;
      out_ld_next      = out_ld_reg;
      out_rd_next      = out_rd_reg;
      out_is_load_next = out_is_load_reg;
      out_fault_next   = out_fault_reg;

      // Drain first; a completion below may refill in the same cycle.
      if (out_valid_reg && out_ready) begin
         out_valid_next = 1'b0;
      end

      case (state_reg)
         IDLE: begin
            if (accept) begin
               if (!in_mem_active || in_fault) begin
                  out_valid_next   = 1'b1;
                  out_alu_next     = in_aluresult;
                  out_ld_next      = '0;
                  out_rd_next      = in_mem_active ? '0 : in_rd;
                  out_is_load_next = 1'b0;
                  out_fault_next   = in_mem_active;
               end else begin
                  state_next  = REQ;
                  addr_next   = {in_aluresult[XLEN-1:OFFW], {OFFW{1'b0}}};
                  off_next    = in_off;
                  funct3_next = in_funct3;
                  rd_next     = in_rd;
                  alu_next    = in_aluresult;
                  we_next     = !in_load;
                  wdata_next  = in_load ? '0 : (in_store_data << {in_off, 3'b000});
                  be_next     = in_load ? '1 : in_be;
               end
            end
         end
         REQ: begin
            if (dmem_req_ready) begin
               if (we_reg) begin
                  state_next       = IDLE;
                  out_valid_next   = 1'b1;
                  out_alu_next     = alu_reg;
                  out_ld_next      = '0;
                  out_rd_next      = '0;
                  out_is_load_next = 1'b0;
                  out_fault_next   = 1'b0;
               end else begin
                  state_next = RESP;
               end
            end
         end
         RESP: begin
            if (dmem_resp_valid) begin
               state_next       = IDLE;
               out_valid_next   = 1'b1;
               out_alu_next     = alu_reg;
               out_ld_next      = load_ext;
               out_rd_next      = rd_reg;
               out_is_load_next = 1'b1;
               out_fault_next   = 1'b0;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign dmem_req_valid = (state_reg == REQ);
   assign dmem_req_addr  = addr_reg;
   assign dmem_req_we    = we_reg;
   assign dmem_req_wdata = wdata_reg;
   assign dmem_req_be    = be_reg;

   assign out_valid      = out_valid_reg;
   assign out_aluresult  = out_alu_reg;
   assign out_loadeddata = out_ld_reg;
   assign out_rd         = out_rd_reg;
   assign out_is_load    = out_is_load_reg;
   assign out_fault      = out_fault_reg;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed scenarios plus a randomized run of mem_stage
// (XLEN=64) against a behavioural model of the stage's transaction rules.
module tb_mem_stage;
   localparam int XLEN = 64;
   localparam int REGW = 6;
   localparam int NB   = XLEN / 8;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            in_valid, in_ready;
   logic [XLEN-1:0] in_aluresult, in_store_data;
   logic [REGW-1:0] in_rd;
   logic            in_mem_active, in_load;
   logic [2:0]      in_funct3;
   logic            dmem_req_valid, dmem_req_ready, dmem_req_we;
   logic [XLEN-1:0] dmem_req_addr, dmem_req_wdata;
   logic [NB-1:0]   dmem_req_be;
   logic            dmem_resp_valid;
   logic [XLEN-1:0] dmem_resp_data;
   logic            out_valid, out_ready, out_is_load, out_fault;
   logic [XLEN-1:0] out_aluresult, out_loadeddata;
   logic [REGW-1:0] out_rd;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [63:0] alu;
      logic [63:0] ld;
      logic [5:0]  rd;
      logic        is_load;
      logic        fault;
   } out_t;

   always #5 clk = ~clk;

   mem_stage #(.XLEN(XLEN), .REGW(REGW)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_aluresult(in_aluresult),
      .in_rd(in_rd), .in_store_data(in_store_data), .in_mem_active(in_mem_active),
      .in_load(in_load), .in_funct3(in_funct3),
      .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
      .dmem_req_addr(dmem_req_addr), .dmem_req_we(dmem_req_we),
      .dmem_req_wdata(dmem_req_wdata), .dmem_req_be(dmem_req_be),
      .dmem_resp_valid(dmem_resp_valid), .dmem_resp_data(dmem_resp_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_aluresult(out_aluresult),
      .out_loadeddata(out_loadeddata), .out_rd(out_rd), .out_is_load(out_is_load),
      .out_fault(out_fault)
   );

   // Reference: pick the addressed bytes of an aligned word, then extend.
   function automatic logic [63:0] model_load(logic [63:0] data, int off, logic [2:0] f3);
      int          sz;
      logic [63:0] v, mask;
      sz   = 1 << f3[1:0];
      v    = data >> (8 * off);
      mask = (sz == 8) ? '1 : ((64'd1 << (8 * sz)) - 64'd1);
      v    = v & mask;
      if (!f3[2] && sz < 8 && v[8*sz-1]) v = v | ~mask;
      return v;
   endfunction

   // Drive/sample 2 time units after the rising edge.
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic idle_inputs();
      in_valid = 0; in_aluresult = '0; in_rd = '0; in_store_data = '0;
      in_mem_active = 0; in_load = 0; in_funct3 = '0;
      dmem_req_ready = 0; dmem_resp_valid = 0; dmem_resp_data = '0; out_ready = 1;
   endtask

   task automatic send(logic [63:0] alu, logic [5:0] rd, logic mem, logic ld,
                       logic [2:0] f3, logic [63:0] sd);
      in_valid = 1; in_aluresult = alu; in_rd = rd; in_mem_active = mem;
      in_load = ld; in_funct3 = f3; in_store_data = sd;
   endtask

   task automatic test_reset();
      idle_inputs();
      #1 reset = 1'b0;
      repeat (3) cyc();
      #1;
      n_checks++; if ({in_ready, dmem_req_valid, dmem_req_addr, dmem_req_we, dmem_req_wdata, dmem_req_be,
                       out_valid, out_aluresult, out_loadeddata, out_rd, out_is_load, out_fault} !== '0) begin
         n_fail++; $display("FAIL reset_outputs: in_ready=%b req_valid=%b out_valid=%b not all zero", in_ready, dmem_req_valid, out_valid);
      end
      reset = 1'b1;
      #1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_release_ready: got %b want 0", in_ready); end
      cyc(); #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_first_cycle_ready: got %b want 1", in_ready); end
      $display("reset: done");
   endtask

   task automatic test_nonmem_burst();
      out_ready = 1;
      for (int i = 0; i < 4; i++) begin
         send(64'h10 + 64'(i), 6'(1 + i), 0, 0, 3'b000, '0);
         #1;
         n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL burst_ready[%0d]: got %b want 1", i, in_ready); end
         cyc();
         n_checks++; if (out_valid !== 1'b1 || out_aluresult !== 64'h10 + 64'(i) || out_rd !== 6'(1 + i)
                         || out_is_load !== 1'b0 || out_fault !== 1'b0 || out_loadeddata !== '0) begin
            n_fail++; $display("FAIL burst_out[%0d]: got v=%b alu=%h rd=%0d want v=1 alu=%h rd=%0d", i, out_valid, out_aluresult, out_rd, 64'h10 + 64'(i), 1 + i);
         end
         $display("burst: entry %0d alu=%h rd=%0d", i, out_aluresult, out_rd);
      end
      in_valid = 0;
      cyc();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL burst_drain: out_valid got %b want 0", out_valid); end
   endtask

   task automatic test_load_byte(logic [2:0] f3, logic [63:0] exp_val);
      out_ready = 1;
      send(64'h1003, 6'd5, 1, 1, f3, '0);
      cyc();
      in_valid = 0; dmem_req_ready = 1;
      #1;
      n_checks++; if (dmem_req_valid !== 1'b1 || dmem_req_addr !== 64'h1000 || dmem_req_be !== 8'hFF || dmem_req_we !== 1'b0) begin
         n_fail++; $display("FAIL load_req f3=%b: got v=%b addr=%h be=%h we=%b want v=1 addr=1000 be=ff we=0", f3, dmem_req_valid, dmem_req_addr, dmem_req_be, dmem_req_we);
      end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL load_early_out: got %b want 0", out_valid); end
      cyc();
      dmem_req_ready = 0; dmem_resp_valid = 1; dmem_resp_data = 64'h0000_0000_8000_0000;
      #1;
      n_checks++; if (dmem_req_valid !== 1'b0 || in_ready !== 1'b0) begin
         n_fail++; $display("FAIL load_resp_wait: req_valid=%b in_ready=%b want 0 0", dmem_req_valid, in_ready);
      end
      cyc();
      dmem_resp_valid = 0;
      n_checks++; if (out_valid !== 1'b1 || out_loadeddata !== exp_val || out_is_load !== 1'b1 || out_rd !== 6'd5
                      || out_fault !== 1'b0 || out_aluresult !== 64'h1003) begin
         n_fail++; $display("FAIL load_out f3=%b: got v=%b data=%h isl=%b rd=%0d want v=1 data=%h isl=1 rd=5", f3, out_valid, out_loadeddata, out_is_load, out_rd, exp_val);
      end
      $display("load: f3=%b data=%h", f3, out_loadeddata);
      cyc();
   endtask

   task automatic test_store_half();
      out_ready = 1;
      send(64'h2006, 6'd7, 1, 0, 3'b001, 64'hABCD);
      cyc();
      in_valid = 0; dmem_req_ready = 0;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_checks++; if (dmem_req_valid !== 1'b1 || dmem_req_addr !== 64'h2000 || dmem_req_be !== 8'hC0
                         || dmem_req_wdata !== 64'hABCD_0000_0000_0000 || dmem_req_we !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL store_req[%0d]: got v=%b addr=%h be=%h wdata=%h we=%b ov=%b want v=1 addr=2000 be=c0 wdata=abcd000000000000 we=1 ov=0",
                               k, dmem_req_valid, dmem_req_addr, dmem_req_be, dmem_req_wdata, dmem_req_we, out_valid);
         end
         cyc();
      end
      dmem_req_ready = 1;
      cyc();
      dmem_req_ready = 0;
      n_checks++; if (out_valid !== 1'b1 || out_rd !== '0 || out_is_load !== 1'b0 || out_fault !== 1'b0 || out_aluresult !== 64'h2006) begin
         n_fail++; $display("FAIL store_out: got v=%b rd=%0d isl=%b f=%b alu=%h want v=1 rd=0 isl=0 f=0 alu=2006", out_valid, out_rd, out_is_load, out_fault, out_aluresult);
      end
      $display("store: alu=%h rd=%0d", out_aluresult, out_rd);
      cyc();
   endtask

   task automatic test_fault(logic [63:0] addr, logic [2:0] f3);
      out_ready = 1;
      send(addr, 6'd9, 1, 1, f3, '0);
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fault_ready f3=%b: got %b want 1", f3, in_ready); end
      cyc();
      in_valid = 0;
      n_checks++; if (dmem_req_valid !== 1'b0 || out_valid !== 1'b1 || out_fault !== 1'b1 || out_rd !== '0 || out_aluresult !== addr) begin
         n_fail++; $display("FAIL fault_out f3=%b: got req_v=%b v=%b fault=%b rd=%0d want req_v=0 v=1 fault=1 rd=0", f3, dmem_req_valid, out_valid, out_fault, out_rd);
      end
      $display("fault: addr=%h f3=%b fault=%b", addr, f3, out_fault);
      cyc();
      n_checks++; if (dmem_req_valid !== 1'b0 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL fault_after: req_v=%b v=%b want 0 0", dmem_req_valid, out_valid);
      end
   endtask

   task automatic test_backpressure();
      out_ready = 0;
      send(64'h55, 6'd9, 0, 0, 3'b000, '0);
      cyc();
      send(64'h66, 6'd10, 0, 0, 3'b000, '0);
      for (int k = 0; k < 5; k++) begin
         #1;
         n_checks++; if (out_valid !== 1'b1 || out_aluresult !== 64'h55 || out_rd !== 6'd9 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_hold[%0d]: got v=%b alu=%h rd=%0d in_ready=%b want v=1 alu=55 rd=9 in_ready=0", k, out_valid, out_aluresult, out_rd, in_ready);
         end
         cyc();
      end
      out_ready = 1;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
      cyc();
      in_valid = 0;
      n_checks++; if (out_valid !== 1'b1 || out_aluresult !== 64'h66 || out_rd !== 6'd10) begin
         n_fail++; $display("FAIL bp_next: got v=%b alu=%h rd=%0d want v=1 alu=66 rd=10", out_valid, out_aluresult, out_rd);
      end
      $display("backpressure: alu=%h rd=%0d", out_aluresult, out_rd);
      cyc();
   endtask

   task automatic test_reset_resp();
      out_ready = 1;
      send(64'h4000, 6'd3, 1, 1, 3'b011, '0);
      cyc();
      in_valid = 0; dmem_req_ready = 1;
      cyc();
      dmem_req_ready = 0;
      reset = 1'b0;
      #1;
      n_checks++; if ({in_ready, dmem_req_valid, dmem_req_addr, dmem_req_we, dmem_req_wdata, dmem_req_be,
                       out_valid, out_aluresult, out_loadeddata, out_rd, out_is_load, out_fault} !== '0) begin
         n_fail++; $display("FAIL resp_reset_outputs: addr=%h be=%h in_ready=%b not all zero", dmem_req_addr, dmem_req_be, in_ready);
      end
      cyc();
      reset = 1'b1;
      cyc();
      dmem_resp_valid = 1; dmem_resp_data = 64'hDEAD_BEEF_1234_5678;
      send(64'h77, 6'd11, 0, 0, 3'b000, '0);
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL resp_reset_ready: got %b want 1", in_ready); end
      cyc();
      in_valid = 0; dmem_resp_valid = 0;
      n_checks++; if (out_valid !== 1'b1 || out_aluresult !== 64'h77 || out_rd !== 6'd11 || out_is_load !== 1'b0 || out_loadeddata !== '0) begin
         n_fail++; $display("FAIL resp_reset_entry: got v=%b alu=%h rd=%0d isl=%b ld=%h want v=1 alu=77 rd=11 isl=0 ld=0", out_valid, out_aluresult, out_rd, out_is_load, out_loadeddata);
      end
      cyc();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL resp_reset_late: out_valid got %b want 0", out_valid); end
      $display("reset during resp: done");
   endtask

   task automatic test_random();
      out_t        exp_q[$];
      out_t        exp_o, got_o;
      logic        req_pending = 0, resp_wait = 0, have_entry = 0, exp_ready, resp_fire;
      int          resp_delay = 0, n_sent = 0, n_cyc = 0, sz, off, p_off;
      logic [63:0] exp_addr = '0, exp_wdata = '0, p_alu = '0;
      logic [7:0]  exp_be = '0;
      logic        exp_we = 0;
      logic [5:0]  p_rd = '0;
      logic [2:0]  p_f3 = '0;
      logic [63:0] e_alu = '0, e_sd = '0;
      logic [5:0]  e_rd = '0;
      logic [2:0]  e_f3 = '0;
      logic        e_mem = 0, e_load = 0;
      while (n_cyc < 4000 && !(n_sent >= 150 && !have_entry && !req_pending && !resp_wait && exp_q.size() == 0)) begin
         n_cyc++;
         if (!have_entry && n_sent < 150 && $urandom_range(3) != 0) begin
            e_mem = ($urandom_range(2) != 0); e_load = $urandom_range(1) == 1;
            e_f3 = 3'($urandom_range(7)); e_rd = 6'($urandom); e_sd = {$urandom, $urandom};
            e_alu = {$urandom, $urandom};
            sz = 1 << e_f3[1:0];
            if ($urandom_range(3) != 0) e_alu[2:0] = 3'(($urandom_range(7) / sz) * sz);
            have_entry = 1;
         end
         in_valid = have_entry; in_aluresult = e_alu; in_rd = e_rd; in_store_data = e_sd;
         in_mem_active = e_mem; in_load = e_load; in_funct3 = e_f3;
         out_ready = ($urandom_range(3) != 0);
         dmem_req_ready = ($urandom_range(2) == 0);
         dmem_resp_data = {$urandom, $urandom};
         if (resp_wait && resp_delay == 0) begin
            dmem_resp_valid = 1;
         end else begin
            dmem_resp_valid = !resp_wait && ($urandom_range(7) == 0);
            if (resp_wait) resp_delay--;
         end
         #1;
         exp_ready = !req_pending && !resp_wait && (exp_q.size() == 0 || out_ready);
         resp_fire = resp_wait && dmem_resp_valid;
         n_checks++; if (in_ready !== exp_ready || out_valid !== (exp_q.size() != 0)) begin
            n_fail++; $display("FAIL rand_hs cyc %0d: in_ready=%b out_valid=%b want %b %b", n_cyc, in_ready, out_valid, exp_ready, exp_q.size() != 0);
         end
         if (out_valid && out_ready && exp_q.size() != 0) begin
            exp_o = exp_q.pop_front();
            got_o = {out_aluresult, out_loadeddata, out_rd, out_is_load, out_fault};
            n_checks++; if (got_o !== exp_o) begin
               n_fail++; $display("FAIL rand_out: got alu=%h ld=%h rd=%0d isl=%b f=%b want alu=%h ld=%h rd=%0d isl=%b f=%b",
                                  got_o.alu, got_o.ld, got_o.rd, got_o.is_load, got_o.fault, exp_o.alu, exp_o.ld, exp_o.rd, exp_o.is_load, exp_o.fault);
            end
            $display("rand txn: alu=%h ld=%h rd=%0d isl=%b f=%b", got_o.alu, got_o.ld, got_o.rd, got_o.is_load, got_o.fault);
         end
         if (dmem_req_valid) begin
            n_checks++; if (!req_pending || dmem_req_addr !== exp_addr || dmem_req_we !== exp_we || dmem_req_be !== exp_be
                            || (exp_we && dmem_req_wdata !== exp_wdata)) begin
               n_fail++; $display("FAIL rand_req: pend=%b addr=%h we=%b be=%h wd=%h want addr=%h we=%b be=%h wd=%h",
                                  req_pending, dmem_req_addr, dmem_req_we, dmem_req_be, dmem_req_wdata, exp_addr, exp_we, exp_be, exp_wdata);
            end
            if (req_pending && dmem_req_ready) begin
               req_pending = 0;
               if (exp_we) exp_q.push_back('{alu: p_alu, ld: '0, rd: '0, is_load: 1'b0, fault: 1'b0});
               else begin resp_wait = 1; resp_delay = $urandom_range(3); end
            end
         end
         if (resp_fire) begin
            resp_wait = 0;
            exp_q.push_back('{alu: p_alu, ld: model_load(dmem_resp_data, p_off, p_f3), rd: p_rd, is_load: 1'b1, fault: 1'b0});
         end
         if (in_valid && in_ready) begin
            have_entry = 0; n_sent++;
            sz  = 1 << e_f3[1:0];
            off = int'(e_alu[2:0]);
            if (!e_mem) begin
               exp_q.push_back('{alu: e_alu, ld: '0, rd: e_rd, is_load: 1'b0, fault: 1'b0});
            end else if (e_f3 == 3'b111 || (off % sz) != 0) begin
               exp_q.push_back('{alu: e_alu, ld: '0, rd: '0, is_load: 1'b0, fault: 1'b1});
            end else begin
               req_pending = 1;
               p_alu = e_alu; p_rd = e_rd; p_f3 = e_f3; p_off = off;
               exp_addr  = e_alu & ~64'h7;
               exp_we    = !e_load;
               exp_wdata = e_sd << (8 * off);
               exp_be    = e_load ? 8'hFF : 8'(((1 << sz) - 1) << off);
            end
         end
         cyc();
      end
      n_checks++; if (n_sent < 150 || req_pending || resp_wait || exp_q.size() != 0) begin
         n_fail++; $display("FAIL rand_timeout: sent=%0d want 150, pending=%b resp_wait=%b queued=%0d", n_sent, req_pending, resp_wait, exp_q.size());
      end
      idle_inputs();
      cyc();
   endtask

   initial begin
      test_reset();
      test_nonmem_burst();
      test_load_byte(3'b000, 64'hFFFF_FFFF_FFFF_FF80);
      test_load_byte(3'b100, 64'h0000_0000_0000_0080);
      test_store_half();
      test_fault(64'h3002, 3'b010);
      test_fault(64'h3000, 3'b111);
      test_backpressure();
      test_reset_resp();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, %0d assertions evaluated", n_checks);
      $fatal(1, "timeout");
   end
endmodule

// File: doc/mem_stage.md
# mem_stage

Parametrised memory-access pipeline stage of the RISC-V core, placed between the EX/MEM and MEM/WB pipeline registers. It generalises the first-generation memory stage in three ways: data width and destination-register width are parameters, it drives a valid/ready data-memory port with variable response latency, and it performs loads and stores with full RISC-V sizing (byte/half/word/double, signed and unsigned), byte enables and misalignment detection. Both sides use valid/ready handshakes, and only one memory transaction is outstanding at a time.

## Interface
- XLEN, 64, datapath and address width; legal values 32 or 64.
- REGW, 6, destination-register tag width.
- NB, XLEN/8, byte lanes (derived; not overridden).

- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  EX/MEM entry valid.
- in_ready  out  1  stage accepts the entry this cycle.
- in_aluresult  in  XLEN  ALU result, or effective address when in_mem_active=1.
- in_rd  in  REGW  destination tag.
- in_store_data  in  XLEN  rs2 value for stores.
- in_mem_active  in  1  entry is a load or store.
- in_load  in  1  1 = load, 0 = store; meaningful only when in_mem_active=1.
- in_funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU, 111 illegal.
- dmem_req_valid  out  1  memory request valid.
- dmem_req_ready  in  1  memory accepts the request.
- dmem_req_addr  out  XLEN  NB-aligned address (low log2(NB) bits zero).
- dmem_req_we  out  1  1 = store.
- dmem_req_wdata  out  XLEN  store data shifted to its byte lanes.
- dmem_req_be  out  NB  byte enables; all ones for loads.
- dmem_resp_valid  in  1  load data valid; always accepted.
- dmem_resp_data  in  XLEN  aligned load word.
- out_valid  out  1  MEM/WB entry valid.
- out_ready  in  1  writeback accepts the entry.
- out_aluresult  out  XLEN  forwarded in_aluresult.
- out_loadeddata  out  XLEN  extended load result; 0 for non-loads.
- out_rd  out  REGW  destination tag; forced to 0 for stores and faults.
- out_is_load  out  1  out_loadeddata selects the writeback value.
- out_fault  out  1  misaligned access or illegal funct3.

## Operation
- FSM states: IDLE, REQ, RESP.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Accept occurs when in_valid && in_ready.
- Non-memory entry is accepted in IDLE. The output register loads in_aluresult and in_rd, sets out_loadeddata=0, out_is_load=0, out_fault=0. The state stays IDLE.
- Memory entry: off = addr[log2(NB)-1:0] and size = 1/2/4/8 bytes from funct3. A fault occurs when off is not a multiple of size, when funct3=111, or when XLEN=32 and funct3 is in {011, 110}. A faulting entry issues no request. The output loads immediately with out_fault=1 and out_rd=0, and the state stays IDLE.
- A legal memory entry moves to REQ. The address, off, funct3, rd, load flag and shifted wdata/be are latched. For a store, be = ((1<<size)-1)<<off and wdata = store_data<<(8*off).
- In REQ: dmem_req_valid=1 and its fields stay stable until dmem_req_ready. On the handshake, a store loads the output (out_rd=0, out_is_load=0) and returns to IDLE; a load moves to RESP.
- In RESP, dmem_resp_valid loads the output. The data is dmem_resp_data>>(8*off), truncated to size, then sign-extended (B/H/W) or zero-extended (BU/HU/WU). out_is_load=1, then the state returns to IDLE.
- The output register holds while out_valid && !out_ready. It is guaranteed empty when a load or store completes, because acceptance requires a free or draining output.
- dmem_resp_valid outside RESP is ignored.

## Timing
- Reset (reset=0, asynchronous): state IDLE and every output 0, including in_ready, dmem_req_valid and out_valid. in_ready rises on the first cycle after reset deasserts.
- Reset asserted mid-transaction abandons it. The memory side is reset by the same signal.
- Latency from accept to out_valid: non-memory and fault entries, 1 cycle. Store, 1 cycle plus the request-wait cycles. Load, at least 2 cycles, because the response arrives no earlier than the cycle after the grant.
- With out_ready held at 1, non-memory entries sustain one per cycle. Each memory operation blocks new entries until it completes.
- An output drain and a new accept can happen in the same cycle.

## Test plan
- Non-memory burst: 4 back-to-back entries (aluresult 0x10..0x13, rd 1..4) with out_ready=1 -> out_valid on 4 consecutive cycles, each 1 cycle after accept, values in order.
- Signed byte load: addr 0x1003, funct3 000, resp_data 0x00000000_80000000 -> req_addr 0x1000, be 0xFF, out_loadeddata 0xFFFFFFFF_FFFFFF80. The same case with funct3 100 -> 0x80.
- Half store: addr 0x2006, data 0xABCD, funct3 001, req_ready delayed 3 cycles -> be 0xC0, wdata 0xABCD<<48, fields stable for 3 cycles, out_valid with out_rd=0 on the cycle after the grant.
- Misaligned word load at 0x3002 -> no dmem_req_valid, out_fault=1, out_rd=0, 1-cycle latency. funct3=111 gives the same result.
- Backpressure: out_ready=0 for 5 cycles with a result pending -> out_* held, in_ready=0. Release -> drain and accept in the same cycle.
- Reset during RESP: assert reset=0 -> outputs 0 immediately. After release, a non-memory entry completes normally and the late dmem_resp_valid is ignored.
